// File: rtl/ta_ldd_pulse.sv
// Laser-diode pulse stage. Each accepted trigger edge waits a programmable
// delay, fires NPULSE drive pulses of PW cycles on a PP-cycle grid, then
// holds off HOLDOFF cycles before re-arming. Trigger edges arriving while
// busy are dropped and latched into a sticky overrun flag.
//
// Handshake: lddr_rdy high means the block is IDLE and the next rising edge
// of ldd_trig is accepted on that cycle; lddr_rdy drops the cycle after an
// accept and returns on the first IDLE cycle after the hold-off window.
module ta_ldd_pulse #(
  parameter int DLY_W   = 8,
  parameter int PW      = 25,
  parameter int PP      = 250,
  parameter int NPULSE  = 4,
  parameter int HOLDOFF = 500,
  parameter int CNT_W   = 4
) (
  input  logic             clk250,
  input  logic             rst,
  input  logic             ldd_trig,
  input  logic [DLY_W-1:0] ldd_dly,
  output logic             lddr_rdy,
  output logic             ldd_out,
  output logic             ldd_busy,
  output logic [CNT_W-1:0] pulse_cnt,
  input  logic             err_clr,
  output logic             ovr_err
);

  // One shared down-counter serves every timed state, so it must hold the
  // longest load value of any of them.
  localparam int MAX_A = (PP > HOLDOFF) ? PP : HOLDOFF;
  localparam int MAX_C = (MAX_A > (1 << DLY_W)) ? MAX_A : (1 << DLY_W);
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0]    HI_LD = TW'(PW - 1);
  localparam logic [TW-1:0]    LO_LD = TW'(PP - PW - 1);
  localparam logic [TW-1:0]    HO_LD = TW'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] NP    = CNT_W'(NPULSE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_PULSE_HI = 3'd2,
    S_PULSE_LO = 3'd3,
    S_HOLD     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             trig_d_q, trig_d_d;
  logic             ldd_out_q, ldd_out_d;
  logic             lddr_rdy_q, lddr_rdy_d;
  logic             ldd_busy_q, ldd_busy_d;
  logic             ovr_err_q, ovr_err_d;
  logic             trig_edge;

  // Next-state, timer, pulse count, overrun flag and registered outputs.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    pulse_cnt_d = pulse_cnt_q;
    trig_d_d    = ldd_trig;
    ovr_err_d   = ovr_err_q;
    trig_edge   = ldd_trig & ~trig_d_q;

    case (state_q)
      S_IDLE: begin
        if (trig_edge) begin
          if (ldd_dly == '0) begin
            // Zero delay: first pulse starts the cycle after accept.
            state_d     = S_PULSE_HI;
            tmr_d       = HI_LD;
            pulse_cnt_d = CNT_W'(1);
          end else begin
            state_d     = S_DELAY;
            tmr_d       = TW'(ldd_dly) - TW'(1);
            pulse_cnt_d = '0;
          end
        end
      end
      S_DELAY: begin
        if (tmr_q == '0) begin
          state_d     = S_PULSE_HI;
          tmr_d       = HI_LD;
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_PULSE_HI: begin
        if (tmr_q == '0) begin
          if (pulse_cnt_q == NP) begin
            state_d = S_HOLD;
            tmr_d   = HO_LD;
          end else begin
            state_d = S_PULSE_LO;
            tmr_d   = LO_LD;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_PULSE_LO: begin
        if (tmr_q == '0) begin
          state_d     = S_PULSE_HI;
          tmr_d       = HI_LD;
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase

    // A dropped edge sets the flag even if a clear arrives the same cycle.
    if (trig_edge && (state_q != S_IDLE)) begin
      ovr_err_d = 1'b1;
    end else if (err_clr) begin
      ovr_err_d = 1'b0;
    end

    // Outputs are registered copies of the state being entered.
    ldd_out_d  = (state_d == S_PULSE_HI);
    lddr_rdy_d = (state_d == S_IDLE);
    ldd_busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset forces the drive low immediately.
  always_ff @(posedge clk250 or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      pulse_cnt_q <= '0;
      trig_d_q    <= 1'b0;
      ldd_out_q   <= 1'b0;
      lddr_rdy_q  <= 1'b1;
      ldd_busy_q  <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pulse_cnt_q <= pulse_cnt_d;
      trig_d_q    <= trig_d_d;
      ldd_out_q   <= ldd_out_d;
      lddr_rdy_q  <= lddr_rdy_d;
      ldd_busy_q  <= ldd_busy_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign ldd_out   = ldd_out_q;
  assign lddr_rdy  = lddr_rdy_q;
  assign ldd_busy  = ldd_busy_q;
  assign pulse_cnt = pulse_cnt_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: doc/ta_ldd_pulse.md
Name: ta_ldd_pulse

Overview:
Laser-diode pulse stage directly downstream of the sync/trigger stage. It consumes `ldd_trig` and returns `lddr_rdy`. Per accepted trigger it waits a programmable delay, emits a burst of NPULSE fixed-width drive pulses on `ldd_out`, then holds off before re-arming. It runs entirely in the clk250 domain, and `ldd_trig` arrives synchronous to clk250.

Parameters:
- DLY_W, 8, width of the per-trigger delay input `ldd_dly`.
- PW, 25, high time of each drive pulse in clk250 cycles; must be >= 1.
- PP, 250, pulse repetition period in cycles; must be > PW.
- NPULSE, 4, pulses per burst; must be >= 1.
- HOLDOFF, 500, cycles after the last pulse falls before re-arming; must be >= 1.
- CNT_W, 4, width of `pulse_cnt`; 2^CNT_W must be > NPULSE.

Ports:
- clk250  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk250 externally.
- ldd_trig  in  1  trigger request; rising-edge sensitive.
- ldd_dly  in  DLY_W  delay from trigger to first pulse, in cycles; sampled on accept.
- lddr_rdy  out  1  high = idle and able to accept a trigger.
- ldd_out  out  1  laser-diode drive pulse, registered.
- ldd_busy  out  1  high in any state other than IDLE.
- pulse_cnt  out  CNT_W  number of pulses issued in the current or most recent burst.
- err_clr  in  1  synchronous clear of `ovr_err`.
- ovr_err  out  1  sticky: a trigger edge arrived while the block was not IDLE.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, `lddr_rdy`=1, `ldd_out`=0, `ldd_busy`=0, `pulse_cnt`=0, `ovr_err`=0.
  - Edge-detect register trig_d=0, so `ldd_trig` already high at reset release counts as an edge.
  - Reset mid-burst drops `ldd_out` immediately, without waiting for a clock edge.
- Edge detect: trig_edge = ldd_trig & ~trig_d. trig_d is registered every cycle.
- States: IDLE, DELAY, PULSE_HI, PULSE_LO, HOLD. All outputs are registered.
- IDLE, on trig_edge in cycle T:
  - Latch D=`ldd_dly`, clear `pulse_cnt`. From T+1, `lddr_rdy`=0 and `ldd_busy`=1.
  - If D=0: go to PULSE_HI, so `ldd_out`=1 from T+1.
  - Else: go to DELAY, with the down-counter loaded to D-1.
  - A level held high does not retrigger.
- DELAY: decrement each cycle. When the counter reaches 0, go to PULSE_HI. First `ldd_out` rise is at cycle T+1+D.
- PULSE_HI:
  - `ldd_out`=1 for exactly PW cycles.
  - `pulse_cnt` increments on the cycle `ldd_out` rises.
  - After PW cycles: if this was pulse NPULSE, go to HOLD; else go to PULSE_LO.
- PULSE_LO: `ldd_out`=0 for PP-PW cycles, then go to PULSE_HI. Rise-to-rise spacing is exactly PP.
- HOLD:
  - `ldd_out`=0 for HOLDOFF cycles, then go to IDLE.
  - `lddr_rdy`=1 and `ldd_busy`=0 on the first IDLE cycle.
  - That cycle is T+1+D+(NPULSE-1)*PP+PW+HOLDOFF.
- Overrun: trig_edge while not IDLE is ignored and sets `ovr_err`, with no effect on the burst.
  - `err_clr` clears `ovr_err`.
  - If `err_clr` and an overrun edge occur in the same cycle, set wins.
- Simultaneous events:
  - trig_edge on the first IDLE cycle after HOLD is accepted normally.
  - trig_edge on the last HOLD cycle is an overrun.
- Counters are sized for max(PP, HOLDOFF, 2^DLY_W) and never wrap inside a state.
- `pulse_cnt` holds its final value (NPULSE) until the next accept.

Test Plan:
- Defaults, D=10, ldd_trig rising at cycle 100:
  - `ldd_out` rises at 111/361/611/861 and falls at 136/386/636/886.
  - `pulse_cnt` ends at 4; `lddr_rdy` low 101..1385 and high at 1386.
- D=0, trigger at cycle 50: `ldd_out` high at 51..75; `lddr_rdy` low from 51.
- Second ldd_trig edge at cycle 400 during the burst:
  - Burst timing unchanged; `ovr_err`=1 from 401.
  - `err_clr` pulse at 2000 gives `ovr_err`=0 at 2001.
- ldd_trig held high 100..3000: exactly one burst; no retrigger at 1386; `ovr_err` stays 0.
- rst asserted at cycle 370 (mid-pulse 2):
  - `ldd_out`=0 and `lddr_rdy`=1 asynchronously, `pulse_cnt`=0.
  - A new edge after release starts a fresh burst with correct timing.
- Edge at cycle 1385 (last HOLD cycle) sets `ovr_err` with no burst; edge at 1386 starts a burst with first rise at 1387+D.
